// File: rtl/rx_buf_ctrl_if.sv
// rx_buf_ctrl_if: single-port receive-buffer bus between the FIFO controller
// and the 4-entry buffer.
//   buf_WR      controller -> buffer  write strobe
//   buf_RD      controller -> buffer  read strobe
//   buf_addr    controller -> buffer  entry address (2 bits)
//   buf_dataIn  controller -> buffer  write data
//   buf_dataOut buffer -> controller  registered read data
// Modports: master = controller side, slave = buffer side.
interface rx_buf_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              buf_WR;
    logic              buf_RD;
    logic [1:0]        buf_addr;
    logic [DATA_W-1:0] buf_dataIn;
    logic [DATA_W-1:0] buf_dataOut;

    modport master (
        output buf_WR,
        output buf_RD,
        output buf_addr,
        output buf_dataIn,
        input  buf_dataOut
    );

    modport slave (
        input  buf_WR,
        input  buf_RD,
        input  buf_addr,
        input  buf_dataIn,
        output buf_dataOut
    );
endinterface

// File: rtl/rx_buf_ctrl.sv
// rx_buf_ctrl: sequences a 4-entry single-port UART receive buffer as a FIFO.
// Ports:
//   Clk, Rst          clock (rising edge), synchronous active-low reset
//   rx_valid, rx_data received-byte pulse and byte
//   rd_req            host read-request pulse
//   clr_ovr           clears the sticky overrun flag
//   rd_data, rd_valid byte returned to the host with a one-cycle valid pulse
//   count, full, empty occupancy (0..4) and its decodes
//   overrun           sticky: a received byte was dropped
//   bus               buffer bus (master side): strobes, address, data
module rx_buf_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rd_req,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [2:0]        count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    rx_buf_ctrl_if.master     bus
);
    localparam int unsigned DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        wptr;
    logic [1:0]        rptr;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic              rd_pend;
    logic              last_grant_rd;   // 1: last grant was READ
    logic              w_ok;
    logic              r_ok;

    assign full  = (count == 3'(DEPTH));
    assign empty = (count == 3'd0);
    assign w_ok  = hold_valid && !full;
    assign r_ok  = rd_pend && !empty;

    // Control FSM, hold register, request latch, pointers and occupancy
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state         <= IDLE;
            wptr          <= 2'd0;
            rptr          <= 2'd0;
            count         <= 3'd0;
            hold_valid    <= 1'b0;
            hold_data     <= '0;
            rd_pend       <= 1'b0;
            last_grant_rd <= 1'b1;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            // A byte arriving while one is still held is dropped
            if (rx_valid && !hold_valid) begin
                hold_data  <= rx_data;
                hold_valid <= 1'b1;
            end

            // Drop wins over a same-cycle clear
            if (rx_valid && hold_valid) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            if (rd_req) begin
                rd_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // On a tie, grant the side that did not win last time
                    if (w_ok && (!r_ok || last_grant_rd)) begin
                        state         <= WRITE;
                        last_grant_rd <= 1'b0;
                    end else if (r_ok) begin
                        state         <= READ;
                        last_grant_rd <= 1'b1;
                        rd_pend       <= 1'b0;
                    end
                end
                WRITE: begin
                    wptr       <= wptr + 2'd1;
                    count      <= count + 3'd1;
                    hold_valid <= 1'b0;
                    state      <= IDLE;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // Buffer output still holds the READ result before this edge
                    rd_data  <= bus.buf_dataOut;
                    rd_valid <= 1'b1;
                    rptr     <= rptr + 2'd1;
                    count    <= count - 3'd1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer strobes, address and write data decoded from state
    always_comb begin
        bus.buf_WR     = 1'b0;
        bus.buf_RD     = 1'b0;
        bus.buf_addr   = 2'd0;
        bus.buf_dataIn = '0;
        case (state)
            WRITE: begin
                bus.buf_WR     = 1'b1;
                bus.buf_addr   = wptr;
                bus.buf_dataIn = hold_data;
            end
            READ: begin
                bus.buf_RD   = 1'b1;
                bus.buf_addr = rptr;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_rx_buf_ctrl.sv
// tb_rx_buf_ctrl: directed self-checking bench for rx_buf_ctrl with a
// behavioural 4-entry single-port buffer attached to the buffer bus.
module tb_rx_buf_ctrl;
    localparam int unsigned DATA_W = 8;

    logic              Clk;
    logic              Rst;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rd_req;
    logic              clr_ovr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    rx_buf_ctrl_if #(.DATA_W(DATA_W)) bus_if ();

    rx_buf_ctrl #(.DATA_W(DATA_W)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rd_req   (rd_req),
        .clr_ovr  (clr_ovr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overrun  (overrun),
        .bus      (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Buffer model: write on WR-only, read on RD-only, output zeroed otherwise
    logic [DATA_W-1:0] mem [4];
    always @(posedge Clk) begin
        if (bus_if.buf_WR && !bus_if.buf_RD) begin
            mem[bus_if.buf_addr] <= bus_if.buf_dataIn;
            bus_if.buf_dataOut   <= '0;
        end else if (bus_if.buf_RD && !bus_if.buf_WR) begin
            bus_if.buf_dataOut <= mem[bus_if.buf_addr];
        end else begin
            bus_if.buf_dataOut <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Receive one byte into an idle controller; check the WRITE cycle
    task automatic wr_byte(input logic [7:0] d, input logic [1:0] a, input logic [2:0] cnt);
        rx_valid = 1'b1;
        rx_data  = d;
        step();
        rx_valid = 1'b0;
        check("wr_pre_strobe", 32'(bus_if.buf_WR), 32'd0);
        step();
        check("wr_strobe", 32'(bus_if.buf_WR), 32'd1);
        check("wr_addr", 32'(bus_if.buf_addr), 32'(a));
        check("wr_data", 32'(bus_if.buf_dataIn), 32'(d));
        step();
        check("wr_count", 32'(count), 32'(cnt));
        check("wr_strobe_off", 32'(bus_if.buf_WR), 32'd0);
    endtask

    // Request one byte from an idle controller; check READ, CAPTURE, return
    task automatic rd_byte(input logic [7:0] d, input logic [1:0] a, input logic [2:0] cnt);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("rd_no_early_valid", 32'(rd_valid), 32'd0);
        step();
        check("rd_strobe", 32'(bus_if.buf_RD), 32'd1);
        check("rd_addr", 32'(bus_if.buf_addr), 32'(a));
        check("rd_no_wr", 32'(bus_if.buf_WR), 32'd0);
        step();
        check("rd_capture_strobe", 32'(bus_if.buf_RD), 32'd0);
        check("rd_capture_valid", 32'(rd_valid), 32'd0);
        step();
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", 32'(rd_data), 32'(d));
        check("rd_count", 32'(count), 32'(cnt));
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            rd_req   = 1'($urandom);
            clr_ovr  = 1'($urandom);
            step();
        end
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_buf_wr", 32'(bus_if.buf_WR), 32'd0);
        check("rst_buf_rd", 32'(bus_if.buf_RD), 32'd0);
        check("rst_buf_addr", 32'(bus_if.buf_addr), 32'd0);
        rx_valid = 1'b0;
        rx_data  = '0;
        rd_req   = 1'b0;
        clr_ovr  = 1'b0;
        Rst      = 1'b1;
    endtask

    initial begin
        Rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rd_req   = 1'b0;
        clr_ovr  = 1'b0;
        #2;

        // Reset state
        do_reset();

        // Single byte round trip
        wr_byte(8'hA5, 2'd0, 3'd1);
        check("single_empty", 32'(empty), 32'd0);
        rd_byte(8'hA5, 2'd0, 3'd0);
        check("single_empty_after", 32'(empty), 32'd1);
        step();
        check("single_valid_pulse", 32'(rd_valid), 32'd0);

        // Fill and wrap
        do_reset();
        wr_byte(8'h11, 2'd0, 3'd1);
        wr_byte(8'h22, 2'd1, 3'd2);
        wr_byte(8'h33, 2'd2, 3'd3);
        wr_byte(8'h44, 2'd3, 3'd4);
        check("fill_full", 32'(full), 32'd1);
        rd_byte(8'h11, 2'd0, 3'd3);
        rd_byte(8'h22, 2'd1, 3'd2);
        wr_byte(8'h55, 2'd0, 3'd3);
        wr_byte(8'h66, 2'd1, 3'd4);
        rd_byte(8'h33, 2'd2, 3'd3);
        rd_byte(8'h44, 2'd3, 3'd2);
        rd_byte(8'h55, 2'd0, 3'd1);
        rd_byte(8'h66, 2'd1, 3'd0);
        check("wrap_empty", 32'(empty), 32'd1);

        // Overrun while full
        wr_byte(8'hA1, 2'd2, 3'd1);
        wr_byte(8'hA2, 2'd3, 3'd2);
        wr_byte(8'hA3, 2'd0, 3'd3);
        wr_byte(8'hA4, 2'd1, 3'd4);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        step();
        rx_data  = 8'h88;
        check("ovr_held_no_write", 32'(bus_if.buf_WR), 32'd0);
        check("ovr_not_yet", 32'(overrun), 32'd0);
        step();
        rx_valid = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_count", 32'(count), 32'd4);
        rd_byte(8'hA1, 2'd2, 3'd3);
        step();
        check("ovr_held_wr", 32'(bus_if.buf_WR), 32'd1);
        check("ovr_held_addr", 32'(bus_if.buf_addr), 32'd2);
        check("ovr_held_data", 32'(bus_if.buf_dataIn), 32'h77);
        step();
        check("ovr_refull", 32'(count), 32'd4);
        check("ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        step();
        rx_data  = 8'hAA;
        clr_ovr  = 1'b1;
        check("ovr_hold_again", 32'(overrun), 32'd0);
        step();
        rx_valid = 1'b0;
        clr_ovr  = 1'b0;
        check("ovr_drop_beats_clear", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_clear2", 32'(overrun), 32'd0);

        // Tie arbitration
        do_reset();
        wr_byte(8'hB1, 2'd0, 3'd1);
        wr_byte(8'hB2, 2'd1, 3'd2);
        rd_byte(8'hB1, 2'd0, 3'd1);
        rx_valid = 1'b1;
        rx_data  = 8'hC1;
        rd_req   = 1'b1;
        step();
        rx_valid = 1'b0;
        rd_req   = 1'b0;
        step();
        check("tie1_wr_first", 32'(bus_if.buf_WR), 32'd1);
        check("tie1_no_rd", 32'(bus_if.buf_RD), 32'd0);
        check("tie1_wr_addr", 32'(bus_if.buf_addr), 32'd2);
        step();
        check("tie1_count", 32'(count), 32'd2);
        step();
        check("tie1_rd_second", 32'(bus_if.buf_RD), 32'd1);
        check("tie1_rd_addr", 32'(bus_if.buf_addr), 32'd1);
        step();
        step();
        check("tie1_rd_valid", 32'(rd_valid), 32'd1);
        check("tie1_rd_data", 32'(rd_data), 32'hB2);
        check("tie1_count_end", 32'(count), 32'd1);
        step();
        wr_byte(8'hC2, 2'd3, 3'd2);
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        rd_req   = 1'b1;
        step();
        rx_valid = 1'b0;
        rd_req   = 1'b0;
        step();
        check("tie2_rd_first", 32'(bus_if.buf_RD), 32'd1);
        check("tie2_no_wr", 32'(bus_if.buf_WR), 32'd0);
        check("tie2_rd_addr", 32'(bus_if.buf_addr), 32'd2);
        step();
        step();
        check("tie2_rd_valid", 32'(rd_valid), 32'd1);
        check("tie2_rd_data", 32'(rd_data), 32'hC1);
        check("tie2_count_mid", 32'(count), 32'd1);
        step();
        check("tie2_wr_second", 32'(bus_if.buf_WR), 32'd1);
        check("tie2_wr_addr", 32'(bus_if.buf_addr), 32'd0);
        check("tie2_wr_data", 32'(bus_if.buf_dataIn), 32'hC3);
        step();
        check("tie2_count_end", 32'(count), 32'd2);

        // Reset while in CAPTURE
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        check("mid_rd_strobe", 32'(bus_if.buf_RD), 32'd1);
        check("mid_rd_addr", 32'(bus_if.buf_addr), 32'd3);
        step();
        Rst = 1'b0;
        step();
        check("mid_no_valid", 32'(rd_valid), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        Rst = 1'b1;
        step();
        check("mid_no_valid_late", 32'(rd_valid), 32'd0);
        wr_byte(8'hD0, 2'd0, 3'd1);
        rd_byte(8'hD0, 2'd0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rx_buf_ctrl.md
# rx_buf_ctrl

Controller that sequences the 4-entry UART receive buffer as a FIFO. It accepts bytes from the UART receiver and host read requests, arbitrates single-port buffer access between them, and owns the write pointer, read pointer and occupancy count. It drives the buffer's write strobe, read strobe, address and write data, and returns read data to the host with a one-cycle valid pulse.

## Interface
- DATA_W, 8, byte width; matches buffer data width
- Clk  in  1  sole clock, rising edge
- Rst  in  1  synchronous, active-low reset (Rst=0 at a rising edge resets)
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  DATA_W  received byte
- rd_req  in  1  one-cycle pulse: host requests the next byte
- clr_ovr  in  1  clears overrun
- rd_data  out  DATA_W  registered byte returned to the host
- rd_valid  out  1  one-cycle pulse: rd_data is valid
- count  out  3  occupancy, 0..4
- full  out  1  count==4
- empty  out  1  count==0
- overrun  out  1  sticky: a received byte was dropped
- buf_WR  out  1  buffer write strobe
- buf_RD  out  1  buffer read strobe
- buf_addr  out  2  buffer address
- buf_dataIn  out  DATA_W  buffer write data
- buf_dataOut  in  DATA_W  buffer read data, registered in the buffer

## Operation
- Buffer contract: a write occurs at the edge where WR=1, RD=0. A read updates dataOut at the edge where RD=1, WR=0. dataOut is forced to 0 at any edge with neither or both strobes. The controller never asserts both strobes.
- Hold register: rx_valid loads hold_data and sets hold_valid. If rx_valid arrives while hold_valid=1, the byte is dropped and overrun is set. hold_valid clears at the end of WRITE.
- rd_req sets rd_pend. rd_pend clears on entry to READ. rd_req while rd_pend=1 is absorbed as one request. A request made while the buffer is empty waits until data is available.
- FSM states: IDLE, WRITE, READ, CAPTURE.
- IDLE:
  - w_ok = hold_valid && !full; r_ok = rd_pend && !empty.
  - If only w_ok, go to WRITE. If only r_ok, go to READ.
  - If both, go round-robin opposite to last_grant.
  - WRITE and READ each set last_grant.
- WRITE (1 cycle):
  - buf_WR=1, buf_addr=wptr, buf_dataIn=hold_data.
  - On exit: wptr+1 (mod 4), count+1, hold_valid cleared; return to IDLE.
- READ (1 cycle):
  - buf_RD=1, buf_addr=rptr; go to CAPTURE.
- CAPTURE (1 cycle):
  - Strobes are low.
  - At exit edge: rd_data<=buf_dataOut, rd_valid<=1, rptr+1 (mod 4), count-1; return to IDLE.
  - Capture uses the pre-edge buf_dataOut. The buffer's same-edge zeroing is harmless.
- Strobe and address defaults: buf_WR, buf_RD, buf_addr and buf_dataIn are combinational from state and registers. They are 0 outside WRITE and READ.
- Pointers wrap modulo 4. count is the only occupancy source; full and empty are decoded from it.
- Overrun: clr_ovr clears overrun. If a drop event and clr_ovr occur in the same cycle, overrun stays 1.
- Reset values: state=IDLE, wptr=rptr=0, count=0, hold_valid=0, rd_pend=0, last_grant=READ (so the first tie goes to write), rd_data=0, rd_valid=0, overrun=0, full=0, empty=1.
- Reset mid-operation aborts the current op. Buffer contents are not cleared; they are discarded by the pointer reset.

## Timing
- Write path, rx_valid sampled at edge E0:
  - hold_valid=1 after E0; WRITE entered at E1, provided the FSM is in IDLE, the buffer is not full and write wins arbitration.
  - Memory is written and count increments at E2.
  - Best-case capture-to-count latency is 2 edges.
- Read path, rd_req sampled at E0:
  - READ entered at E1 (best case); buffer dataOut updated at E2.
  - rd_data and rd_valid are registered at E3; rd_valid is high for exactly the cycle after E3.
- Operations are one at a time; each starts from IDLE. Throughput: one write per 2 cycles, one read per 3 cycles.
- While full, hold_valid persists. A further rx_valid sets overrun; the held byte is kept.

## Test plan
- Reset: hold Rst=0 for 2 cycles with random inputs -> all outputs at reset values, buf_WR=buf_RD=0, empty=1, count=0.
- Single byte: rx_valid with 0xA5, then rd_req -> buf_WR with addr 0 at E1-E2; rd_data=0xA5, rd_valid pulses 3 edges after rd_req; count returns 0.
- Fill and wrap: write 0x11,0x22,0x33,0x44 -> full=1, count=4. Read 2, write 0x55,0x66 -> the writes use addr 0,1. Read 4 -> returns 0x33,0x44,0x55,0x66 in order.
- Overrun: when full, send rx_valid 0x77 then 0x88 -> 0x88 dropped and overrun=1. After one read, 0x77 is written. clr_ovr -> overrun=0.
- Tie arbitration: with hold_valid=1 and rd_pend=1 both present in IDLE from reset -> WRITE first, then READ. Repeat the tie -> the grants alternate.
- Reset mid-read: assert Rst=0 in CAPTURE -> no rd_valid pulse, count=0, empty=1, next write goes to addr 0.
